// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared constants, command opcodes and FSM states for the frame VRAM writer
package vram_pkg;

  localparam int FRAME_W = 128;
  localparam int FRAME_H = 128;
  localparam int ADDR_W  = 14;
  localparam int COORD_W = 8;

  typedef enum logic [1:0] {
    OP_FILL0  = 2'd0,
    OP_FILL1  = 2'd1,
    OP_STREAM = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/vram_rect_counter.sv
// rtl/vram_rect_counter.sv - row-major col/row walker over a latched rectangle with clipping and address
module vram_rect_counter
  import vram_pkg::*;
#(
  parameter int FRAME_W = vram_pkg::FRAME_W,
  parameter int FRAME_H = vram_pkg::FRAME_H,
  parameter int ADDR_W  = vram_pkg::ADDR_W,
  parameter int COORD_W = vram_pkg::COORD_W
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [COORD_W-1:0] i_x,
  input  logic [COORD_W-1:0] i_y,
  input  logic [COORD_W-1:0] i_w,
  input  logic [COORD_W-1:0] i_h,
  output logic               o_last,
  output logic               o_in_bounds,
  output logic [ADDR_W-1:0]  o_addr
);

  logic [COORD_W-1:0] r_x, r_y, r_w, r_h, r_col, r_row;
  logic [COORD_W:0]   w_px, w_py;
  logic               w_col_last;

  // One extra bit so a rectangle hanging past the edge clips instead of wrapping.
  assign w_px        = {1'b0, r_x} + {1'b0, r_col};
  assign w_py        = {1'b0, r_y} + {1'b0, r_row};
  assign w_col_last  = (r_col == r_w - COORD_W'(1));
  assign o_last      = w_col_last && (r_row == r_h - COORD_W'(1));
  assign o_in_bounds = (w_px < (COORD_W+1)'(FRAME_W)) && (w_py < (COORD_W+1)'(FRAME_H));
  assign o_addr      = ADDR_W'(32'(w_py) * 32'(FRAME_W) + 32'(w_px));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_x   <= '0;
      r_y   <= '0;
      r_w   <= '0;
      r_h   <= '0;
      r_col <= '0;
      r_row <= '0;
    end else if (i_load) begin
      r_x   <= i_x;
      r_y   <= i_y;
      r_w   <= i_w;
      r_h   <= i_h;
      r_col <= '0;
      r_row <= '0;
    end else if (i_step) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= r_row + COORD_W'(1);
      end else begin
        r_col <= r_col + COORD_W'(1);
      end
    end
  end

endmodule

// File: rtl/vram_frame_writer.sv
// rtl/vram_frame_writer.sv - rectangle fill/stream engine driving single-bit writes into the frame VRAM
module vram_frame_writer
  import vram_pkg::*;
#(
  parameter int FRAME_W     = vram_pkg::FRAME_W,
  parameter int FRAME_H     = vram_pkg::FRAME_H,
  parameter int ADDR_W      = vram_pkg::ADDR_W,
  parameter int COORD_W     = vram_pkg::COORD_W,
  parameter bit GATE_VBLANK = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [1:0]         i_cmd_op,
  input  logic [COORD_W-1:0] i_cmd_x,
  input  logic [COORD_W-1:0] i_cmd_y,
  input  logic [COORD_W-1:0] i_cmd_w,
  input  logic [COORD_W-1:0] i_cmd_h,
  input  logic               i_pix_valid,
  output logic               o_pix_ready,
  input  logic               i_pix_data,
  input  logic               i_vblank,
  output logic               o_vram_en,
  output logic [1:0]         o_vram_we,
  output logic [ADDR_W-1:0]  o_vram_addr,
  output logic               o_vram_din,
  output logic               o_busy,
  output logic               o_done
);

  state_e              r_state, w_state_next;
  op_e                 r_op;
  logic                r_vram_en, r_vram_din;
  logic [1:0]          r_vram_we;
  logic [ADDR_W-1:0]   r_vram_addr;
  logic                w_accept, w_empty, w_gate_ok, w_step, w_last, w_in_bounds, w_din;
  logic [ADDR_W-1:0]   w_addr;

  assign w_accept  = (r_state == ST_IDLE) && i_cmd_valid;
  assign w_empty   = (i_cmd_w == '0) || (i_cmd_h == '0);
  assign w_gate_ok = !GATE_VBLANK || i_vblank;
  assign w_din     = (r_op == OP_FILL1) || ((r_op == OP_STREAM) && i_pix_data);

  vram_rect_counter #(
    .FRAME_W(FRAME_W), .FRAME_H(FRAME_H), .ADDR_W(ADDR_W), .COORD_W(COORD_W)
  ) u_counter (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_accept),
    .i_step     (w_step),
    .i_x        (i_cmd_x),
    .i_y        (i_cmd_y),
    .i_w        (i_cmd_w),
    .i_h        (i_cmd_h),
    .o_last     (w_last),
    .o_in_bounds(w_in_bounds),
    .o_addr     (w_addr)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_op    <= OP_FILL0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) r_op <= op_e'(i_cmd_op);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = w_empty ? ST_DONE : ST_RUN;
      ST_RUN:  if (w_step && w_last) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_cmd_ready = (r_state == ST_IDLE);
    o_busy      = (r_state == ST_RUN);
    o_done      = (r_state == ST_DONE);
    o_pix_ready = (r_state == ST_RUN) && (r_op == OP_STREAM) && w_gate_ok;
    w_step      = (r_state == ST_RUN) && ((r_op != OP_STREAM) || i_pix_valid) && w_gate_ok;
  end

  // Clipped pixels still step (and consume stream data) but issue we=00.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_vram_en   <= 1'b0;
      r_vram_we   <= 2'b00;
      r_vram_addr <= '0;
      r_vram_din  <= 1'b0;
    end else if (w_step) begin
      r_vram_en   <= 1'b1;
      r_vram_we   <= w_in_bounds ? 2'b11 : 2'b00;
      r_vram_addr <= w_addr;
      r_vram_din  <= w_din;
    end else begin
      r_vram_en   <= 1'b0;
      r_vram_we   <= 2'b00;
    end
  end

  assign o_vram_en   = r_vram_en;
  assign o_vram_we   = r_vram_we;
  assign o_vram_addr = r_vram_addr;
  assign o_vram_din  = r_vram_din;

endmodule

// File: tb/tb_vram_frame_writer.sv
// tb/tb_vram_frame_writer.sv - directed self-checking bench for vram_frame_writer
module tb_vram_frame_writer;

  logic        clk, reset;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_x, cmd_y, cmd_w, cmd_h;
  logic        pix_valid, pix_ready, pix_data, vblank;
  logic        vram_en, vram_din, busy, done;
  logic [1:0]  vram_we;
  logic [13:0] vram_addr;
  int          nvec, nfail;

  vram_frame_writer dut (
    .i_clk(clk), .i_reset(reset),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op),
    .i_cmd_x(cmd_x), .i_cmd_y(cmd_y), .i_cmd_w(cmd_w), .i_cmd_h(cmd_h),
    .i_pix_valid(pix_valid), .o_pix_ready(pix_ready), .i_pix_data(pix_data),
    .i_vblank(vblank),
    .o_vram_en(vram_en), .o_vram_we(vram_we), .o_vram_addr(vram_addr), .o_vram_din(vram_din),
    .o_busy(busy), .o_done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one command for one cycle; returns at the negedge after the accept edge.
  task automatic issue_cmd(input logic [1:0] op, input logic [7:0] x, y, w, h);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; pix_valid = 1'b1;
    repeat (2) @(negedge clk);
    nvec++; if (vram_en !== 1'b0) begin nfail++; $display("FAIL reset_en got %b want 0", vram_en); end
    nvec++; if (vram_we !== 2'b00) begin nfail++; $display("FAIL reset_we got %b want 00", vram_we); end
    nvec++; if (vram_addr !== 14'd0) begin nfail++; $display("FAIL reset_addr got %0d want 0", vram_addr); end
    nvec++; if (vram_din !== 1'b0) begin nfail++; $display("FAIL reset_din got %b want 0", vram_din); end
    nvec++; if (done !== 1'b0 || busy !== 1'b0) begin nfail++; $display("FAIL reset_done_busy got %b%b want 00", done, busy); end
    nvec++; if (pix_ready !== 1'b0) begin nfail++; $display("FAIL reset_pix_ready got %b want 0", pix_ready); end
    reset = 1'b0; pix_valid = 1'b0;
    @(negedge clk);
    nvec++; if (cmd_ready !== 1'b1) begin nfail++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
  endtask

  task automatic test_fill1();
    logic [13:0] exp_addr [4] = '{14'd0, 14'd1, 14'd128, 14'd129};
    issue_cmd(2'd1, 8'd0, 8'd0, 8'd2, 8'd2);
    nvec++; if (busy !== 1'b1) begin nfail++; $display("FAIL fill1_busy got %b want 1", busy); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      nvec++; if (vram_en !== 1'b1 || vram_we !== 2'b11 || vram_din !== 1'b1)
        begin nfail++; $display("FAIL fill1_wr%0d en/we/din got %b/%b/%b want 1/11/1", i, vram_en, vram_we, vram_din); end
      nvec++; if (vram_addr !== exp_addr[i]) begin nfail++; $display("FAIL fill1_addr%0d got %0d want %0d", i, vram_addr, exp_addr[i]); end
      nvec++; if (done !== (i == 3)) begin nfail++; $display("FAIL fill1_done%0d got %b want %b", i, done, (i == 3)); end
    end
    @(negedge clk);
    nvec++; if (vram_en !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1)
      begin nfail++; $display("FAIL fill1_end en/done/rdy got %b/%b/%b want 0/0/1", vram_en, done, cmd_ready); end
  endtask

  task automatic test_stream_clip();
    logic [3:0] bits = 4'b1101;
    logic [1:0] exp_we [4] = '{2'b11, 2'b11, 2'b00, 2'b00};
    issue_cmd(2'd2, 8'd126, 8'd0, 8'd4, 8'd1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin
        @(negedge clk);
        nvec++; if (vram_en !== 1'b1 || vram_we !== exp_we[i-1])
          begin nfail++; $display("FAIL stream_wr%0d en/we got %b/%b want 1/%b", i-1, vram_en, vram_we, exp_we[i-1]); end
        nvec++; if (vram_addr !== 14'(126 + i - 1) || vram_din !== bits[i-1])
          begin nfail++; $display("FAIL stream_wr%0d addr/din got %0d/%b want %0d/%b", i-1, vram_addr, vram_din, 126 + i - 1, bits[i-1]); end
      end
      if (i < 4) begin pix_valid = 1'b1; pix_data = bits[i]; end
      else pix_valid = 1'b0;
      #1;
      nvec++; if (pix_ready !== (i < 4)) begin nfail++; $display("FAIL stream_pix_ready%0d got %b want %b", i, pix_ready, (i < 4)); end
    end
    nvec++; if (done !== 1'b1) begin nfail++; $display("FAIL stream_done got %b want 1", done); end
  endtask

  task automatic test_empty();
    issue_cmd(2'd0, 8'd3, 8'd3, 8'd0, 8'd5);
    nvec++; if (done !== 1'b1 || vram_en !== 1'b0 || cmd_ready !== 1'b0)
      begin nfail++; $display("FAIL empty_done done/en/rdy got %b/%b/%b want 1/0/0", done, vram_en, cmd_ready); end
    @(negedge clk);
    nvec++; if (done !== 1'b0 || vram_en !== 1'b0 || cmd_ready !== 1'b1)
      begin nfail++; $display("FAIL empty_after done/en/rdy got %b/%b/%b want 0/0/1", done, vram_en, cmd_ready); end
  endtask

  task automatic test_vblank_stall();
    logic        exp_en   [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [13:0] exp_addr [7] = '{14'd0, 14'd1, 14'd1, 14'd1, 14'd1, 14'd2, 14'd3};
    logic        vb_next  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    issue_cmd(2'd1, 8'd0, 8'd0, 8'd4, 8'd1);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      nvec++; if (vram_en !== exp_en[k] || vram_addr !== exp_addr[k])
        begin nfail++; $display("FAIL vblank_c%0d en/addr got %b/%0d want %b/%0d", k, vram_en, vram_addr, exp_en[k], exp_addr[k]); end
      nvec++; if (busy !== (k < 6) || done !== (k == 6))
        begin nfail++; $display("FAIL vblank_c%0d busy/done got %b/%b want %b/%b", k, busy, done, (k < 6), (k == 6)); end
      vblank = vb_next[k];
    end
  endtask

  task automatic test_stream_gaps();
    logic vs [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic ds [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int   k = 0;
    pix_valid = 1'b1;
    #1;
    nvec++; if (pix_ready !== 1'b0) begin nfail++; $display("FAIL gaps_idle_pix_ready got %b want 0", pix_ready); end
    pix_valid = 1'b0;
    issue_cmd(2'd2, 8'd10, 8'd3, 8'd3, 8'd1);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(negedge clk);
        nvec++; if (vram_en !== vs[i-1]) begin nfail++; $display("FAIL gaps_en%0d got %b want %b", i-1, vram_en, vs[i-1]); end
        if (vs[i-1]) begin
          nvec++; if (vram_addr !== 14'(394 + k) || vram_din !== ds[i-1] || vram_we !== 2'b11)
            begin nfail++; $display("FAIL gaps_wr%0d addr/din/we got %0d/%b/%b want %0d/%b/11", k, vram_addr, vram_din, vram_we, 394 + k, ds[i-1]); end
          k++;
        end
      end
      if (i < 5) begin pix_valid = vs[i]; pix_data = ds[i]; end
      else pix_valid = 1'b0;
      #1;
      nvec++; if (pix_ready !== (i < 5)) begin nfail++; $display("FAIL gaps_pix_ready%0d got %b want %b", i, pix_ready, (i < 5)); end
    end
    nvec++; if (done !== 1'b1 || k != 3) begin nfail++; $display("FAIL gaps_done done/writes got %b/%0d want 1/3", done, k); end
  endtask

  task automatic test_reset_mid_run();
    issue_cmd(2'd1, 8'd0, 8'd0, 8'd8, 8'd8);
    @(negedge clk);
    nvec++; if (vram_en !== 1'b1 || vram_addr !== 14'd0) begin nfail++; $display("FAIL abort_first en/addr got %b/%0d want 1/0", vram_en, vram_addr); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    nvec++; if (vram_en !== 1'b0 || vram_we !== 2'b00 || busy !== 1'b0 || done !== 1'b0)
      begin nfail++; $display("FAIL abort_after en/we/busy/done got %b/%b/%b/%b want 0/00/0/0", vram_en, vram_we, busy, done); end
    @(negedge clk);
    nvec++; if (vram_en !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1)
      begin nfail++; $display("FAIL abort_idle en/done/rdy got %b/%b/%b want 0/0/1", vram_en, done, cmd_ready); end
    issue_cmd(2'd0, 8'd5, 8'd1, 8'd1, 8'd1);
    nvec++; if (busy !== 1'b1) begin nfail++; $display("FAIL abort_next_busy got %b want 1", busy); end
    @(negedge clk);
    nvec++; if (vram_en !== 1'b1 || vram_we !== 2'b11 || vram_addr !== 14'd133 || vram_din !== 1'b0 || done !== 1'b1)
      begin nfail++; $display("FAIL abort_next_wr en/we/addr/din/done got %b/%b/%0d/%b/%b want 1/11/133/0/1", vram_en, vram_we, vram_addr, vram_din, done); end
  endtask

  initial begin
    nvec = 0; nfail = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0;
    pix_valid = 1'b0; pix_data = 1'b0; vblank = 1'b1;
    test_reset();
    test_fill1();
    test_stream_clip();
    test_empty();
    test_vblank_stall();
    test_stream_gaps();
    test_reset_mid_run();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
